// File: rtl/mdmc_ahb_slv_if.sv
// AHB-lite bus bundle between the mdmc AHB master and the mdmc SRAM responder.
// Carries address/control, write data, bus-level ready and the slave response.
interface mdmc_ahb_slv_if #(
  parameter int DWIDTH = 32
);
  logic              hsel;
  logic [31:0]       haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [3:0]        hsize;
  logic [DWIDTH-1:0] hwdata;
  logic              hready;
  logic              hreadyout;
  logic              hresp;
  logic [DWIDTH-1:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/mdmc_ahb_slv.sv
// mdmc_ahb_slv: AHB-lite responder mapping transfers onto a single-port SRAM
// with 1-cycle read latency. Zero wait states except one wait when a read
// address phase lands on a write data phase (port conflict); illegal
// accesses get the two-cycle ERROR response and never strobe the memory.
// Optional build macro MDMC_AHB_SLV_SUBWORD_EN: adds mem_be and accepts
// aligned sub-word transfers (hsize < native size).
module mdmc_ahb_slv #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 12
) (
  input  logic                hclk,
  input  logic                hreset,
  mdmc_ahb_slv_if.slave       bus,
  output logic                mem_cs,
  output logic                mem_we,
  output logic [AWIDTH-1:0]   mem_addr,
  output logic [DWIDTH-1:0]   mem_wdata,
  input  logic [DWIDTH-1:0]   mem_rdata
`ifdef MDMC_AHB_SLV_SUBWORD_EN
  ,
  output logic [DWIDTH/8-1:0] mem_be
`endif
);

  localparam int NB  = DWIDTH / 8;
  localparam int OFF = $clog2(NB);
  // Byte-offset bits inside a word.
  localparam logic [31:0] OFF_MASK = (32'd1 << OFF) - 32'd1;
  // Bits between the top of the word address and the ignored base byte.
  localparam logic [31:0] HI_MASK  = 32'h00FF_FFFF & ~((32'd1 << (OFF + AWIDTH)) - 32'd1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RDW,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [AWIDTH-1:0]   r_addr;
  logic [AWIDTH-1:0]   w_live_addr;
  logic                w_port_open;
  logic                w_accept;
  logic                w_range_err;
  logic                w_align_err;
  logic                w_size_ok;
  logic                w_legal;
  logic                w_capture;
  logic                w_hreadyout;
  logic                w_hresp;
  logic [DWIDTH-1:0]   w_hrdata;
  logic                w_unused;

  assign w_live_addr = bus.haddr[OFF +: AWIDTH];
  assign w_range_err = |(bus.haddr & HI_MASK);

  // New address phases are only taken while we are driving hreadyout high.
  assign w_port_open = (r_state != S_RDW) && (r_state != S_ERR1);
  assign w_accept    = bus.hsel && bus.hready && bus.htrans[1] && w_port_open;

`ifdef MDMC_AHB_SLV_SUBWORD_EN
  logic [31:0]   w_size_mask;
  logic [31:0]   w_lane;
  logic [31:0]   w_nbytes;
  logic [NB-1:0] w_be;
  logic [NB-1:0] r_be;

  assign w_size_ok   = (bus.hsize <= 4'(OFF));
  assign w_size_mask = (32'd1 << bus.hsize) - 32'd1;
  assign w_align_err = |(bus.haddr & OFF_MASK & w_size_mask);
  assign w_lane      = bus.haddr & OFF_MASK;
  assign w_nbytes    = 32'd1 << bus.hsize;

  // One enable per byte lane covered by [lane, lane + 2^hsize).
  for (genvar gi = 0; gi < NB; gi++) begin : g_be
    assign w_be[gi] = (32'(gi) >= w_lane) && (32'(gi) < (w_lane + w_nbytes));
  end
`else
  assign w_size_ok   = (bus.hsize == 4'(OFF));
  assign w_align_err = |(bus.haddr & OFF_MASK);
`endif

  assign w_legal   = w_size_ok && !w_align_err && !w_range_err;
  // Address is held for the WR data phase and for the delayed read in RDW.
  assign w_capture = w_accept && w_legal && (bus.hwrite || (r_state == S_WR));

  // State register and captured address/lane enables.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_capture) begin
        r_addr <= w_live_addr;
      end
    end
  end

`ifdef MDMC_AHB_SLV_SUBWORD_EN
  // Byte enables of the accepted write, used in its data phase.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_be <= '0;
    end else if (w_capture && bus.hwrite) begin
      r_be <= w_be;
    end
  end
`endif

  // Next-state decode plus bus response and memory strobes.
  always_comb begin
    w_state_next = S_IDLE;
    w_hreadyout  = 1'b1;
    w_hresp      = 1'b0;
    w_hrdata     = '0;
    mem_cs       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = w_live_addr;

    case (r_state)
      S_WR: begin
        mem_cs   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = r_addr;
      end
      S_RD: begin
        w_hrdata = mem_rdata;
      end
      S_RDW: begin
        w_hreadyout  = 1'b0;
        mem_cs       = 1'b1;
        mem_addr     = r_addr;
        w_state_next = S_RD;
      end
      S_ERR1: begin
        w_hreadyout  = 1'b0;
        w_hresp      = 1'b1;
        w_state_next = S_ERR2;
      end
      S_ERR2: begin
        w_hresp = 1'b1;
      end
      default: begin
      end
    endcase

    if (w_accept) begin
      if (!w_legal) begin
        w_state_next = S_ERR1;
      end else if (bus.hwrite) begin
        w_state_next = S_WR;
      end else if (r_state == S_WR) begin
        w_state_next = S_RDW;
      end else begin
        // Port is free: issue the read strobe in the address phase itself.
        w_state_next = S_RD;
        mem_cs       = 1'b1;
        mem_we       = 1'b0;
        mem_addr     = w_live_addr;
      end
    end

    // A pending write or delayed read is dropped while reset is high.
    if (hreset) begin
      mem_cs = 1'b0;
      mem_we = 1'b0;
    end
  end

`ifdef MDMC_AHB_SLV_SUBWORD_EN
  // Writes use the captured lanes; reads always fetch the whole word.
  always_comb begin
    mem_be = '0;
    if (mem_cs) begin
      mem_be = mem_we ? r_be : {NB{1'b1}};
    end
  end
`endif

  assign mem_wdata     = bus.hwdata;
  assign bus.hreadyout = w_hreadyout;
  assign bus.hresp     = w_hresp;
  assign bus.hrdata    = w_hrdata;

  // htrans[0] only separates NONSEQ from SEQ, which are treated alike.
  assign w_unused = bus.htrans[0];

endmodule

// File: tb/tb_mdmc_ahb_slv.sv
// Directed bench for mdmc_ahb_slv: per-cycle vector table plus a bounded
// wait-state sequence; a small behavioural SRAM sits on the memory port.
module tb_mdmc_ahb_slv;
  localparam int DW = 32;
  localparam int AW = 12;
  localparam logic [1:0] IDL = 2'b00;
  localparam logic [1:0] BSY = 2'b01;
  localparam logic [1:0] NSQ = 2'b10;
  localparam logic [3:0] W   = 4'd2;
  localparam int NV = 31;

  logic          clk;
  logic          hreset;
  logic          mem_cs;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
`ifdef MDMC_AHB_SLV_SUBWORD_EN
  logic [DW/8-1:0] mem_be;
`endif

  int n_checks = 0;
  int n_errors = 0;

  mdmc_ahb_slv_if #(.DWIDTH(DW)) bus ();

  // Single slave on the bus: bus-level ready follows our own hreadyout.
  assign bus.hready = bus.hreadyout;

  mdmc_ahb_slv #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .hclk      (clk),
    .hreset    (hreset),
    .bus       (bus),
    .mem_cs    (mem_cs),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef MDMC_AHB_SLV_SUBWORD_EN
    ,
    .mem_be    (mem_be)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM, 1-cycle registered read.
  logic [DW-1:0] sram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata <= sram[mem_addr];
    end
  end

  typedef struct {
    logic        rst;
    logic        sel;
    logic [1:0]  tr;
    logic        wr;
    logic [3:0]  sz;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rdy;
    logic        resp;
    logic [31:0] rdata;
    logic        cs;
    logic        we;
    logic [11:0] maddr;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(input logic rst, input logic sel, input logic [1:0] tr,
                              input logic wr, input logic [3:0] sz, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic rdy, input logic resp,
                              input logic [31:0] rdata, input logic cs, input logic we,
                              input logic [11:0] maddr);
    vec_t v;
    v.rst = rst; v.sel = sel; v.tr = tr; v.wr = wr; v.sz = sz; v.addr = addr;
    v.wdata = wdata; v.rdy = rdy; v.resp = resp; v.rdata = rdata; v.cs = cs;
    v.we = we; v.maddr = maddr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic sel, input logic [1:0] tr, input logic wr,
                       input logic [3:0] sz, input logic [31:0] addr, input logic [31:0] wdata);
    bus.hsel   = sel;
    bus.htrans = tr;
    bus.hwrite = wr;
    bus.hsize  = sz;
    bus.haddr  = addr;
    bus.hwdata = wdata;
  endtask

  initial begin
    int   waits;
    int   k;
    logic got;

    //                rst sel tr   wr sz   addr           wdata          rdy resp rdata          cs we maddr
    vecs[0]  = mk(0, 1, NSQ, 1, W,    32'h0400_0010, 32'h0,         1, 0, 32'h0,         0, 0, 12'd0);
    vecs[1]  = mk(0, 0, IDL, 0, W,    32'h0,         32'hDEADBEEF,  1, 0, 32'h0,         1, 1, 12'd4);
    vecs[2]  = mk(0, 0, IDL, 0, W,    32'h0,         32'h0,         1, 0, 32'h0,         0, 0, 12'd0);
    vecs[3]  = mk(0, 1, NSQ, 0, W,    32'h0400_0010, 32'h0,         1, 0, 32'h0,         1, 0, 12'd4);
    vecs[4]  = mk(0, 0, IDL, 0, W,    32'h0,         32'h0,         1, 0, 32'hDEADBEEF,  0, 0, 12'd0);
    vecs[5]  = mk(0, 1, NSQ, 1, W,    32'h8,         32'h0,         1, 0, 32'h0,         0, 0, 12'd0);
    vecs[6]  = mk(0, 1, NSQ, 0, W,    32'h8,         32'hA5A5A5A5,  1, 0, 32'h0,         1, 1, 12'd2);
    vecs[7]  = mk(0, 0, IDL, 0, W,    32'h0,         32'h0,         0, 0, 32'h0,         1, 0, 12'd2);
    vecs[8]  = mk(0, 0, IDL, 0, W,    32'h0,         32'h0,         1, 0, 32'hA5A5A5A5,  0, 0, 12'd0);
    vecs[9]  = mk(0, 1, NSQ, 0, W,    32'h4000,      32'h0,         1, 0, 32'h0,         0, 0, 12'd0);
    vecs[10] = mk(0, 0, IDL, 0, W,    32'h0,         32'h0,         0, 1, 32'h0,         0, 0, 12'd0);
    vecs[11] = mk(0, 0, IDL, 0, W,    32'h0,         32'h0,         1, 1, 32'h0,         0, 0, 12'd0);
    vecs[12] = mk(0, 1, NSQ, 0, 4'd1, 32'h0,         32'h0,         1, 0, 32'h0,         0, 0, 12'd0);
    vecs[13] = mk(0, 0, IDL, 0, W,    32'h0,         32'h0,         0, 1, 32'h0,         0, 0, 12'd0);
    vecs[14] = mk(0, 1, NSQ, 1, W,    32'h2,         32'h0,         1, 1, 32'h0,         0, 0, 12'd0);
    vecs[15] = mk(0, 1, NSQ, 0, W,    32'h10,        32'h0,         0, 1, 32'h0,         0, 0, 12'd0);
    vecs[16] = mk(0, 1, NSQ, 0, W,    32'h10,        32'h0,         1, 1, 32'h0,         1, 0, 12'd4);
    vecs[17] = mk(0, 1, NSQ, 1, W,    32'hC,         32'h0,         1, 0, 32'hDEADBEEF,  0, 0, 12'd0);
    vecs[18] = mk(0, 0, IDL, 0, W,    32'h0,         32'h11112222,  1, 0, 32'h0,         1, 1, 12'd3);
    vecs[19] = mk(0, 1, NSQ, 1, W,    32'hC,         32'h0,         1, 0, 32'h0,         0, 0, 12'd0);
    vecs[20] = mk(1, 0, IDL, 0, W,    32'h0,         32'h33334444,  1, 0, 32'h0,         0, 0, 12'd0);
    vecs[21] = mk(0, 1, NSQ, 0, W,    32'hC,         32'h0,         1, 0, 32'h0,         1, 0, 12'd3);
    vecs[22] = mk(0, 1, BSY, 0, W,    32'h10,        32'h0,         1, 0, 32'h11112222,  0, 0, 12'd0);
    vecs[23] = mk(0, 0, NSQ, 0, W,    32'h10,        32'h0,         1, 0, 32'h0,         0, 0, 12'd0);
    vecs[24] = mk(0, 1, NSQ, 0, W,    32'h10,        32'h0,         1, 0, 32'h0,         1, 0, 12'd4);
    vecs[25] = mk(0, 0, NSQ, 0, W,    32'h10,        32'h0,         1, 0, 32'hDEADBEEF,  0, 0, 12'd0);
    vecs[26] = mk(0, 1, BSY, 0, W,    32'h10,        32'h0,         1, 0, 32'h0,         0, 0, 12'd0);
    vecs[27] = mk(0, 1, NSQ, 0, W,    32'h8,         32'h0,         1, 0, 32'h0,         1, 0, 12'd2);
    vecs[28] = mk(0, 1, NSQ, 0, W,    32'h10,        32'h0,         1, 0, 32'hA5A5A5A5,  1, 0, 12'd4);
    vecs[29] = mk(0, 0, IDL, 0, W,    32'h0,         32'h0,         1, 0, 32'hDEADBEEF,  0, 0, 12'd0);
    vecs[30] = mk(0, 0, IDL, 0, W,    32'h0,         32'h0,         1, 0, 32'h0,         0, 0, 12'd0);

    // Reset with idle bus, then check reset-state outputs.
    hreset = 1'b1;
    drive(1'b0, IDL, 1'b0, W, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_hreadyout", 32'(bus.hreadyout), 32'd1);
    check("reset_hresp",     32'(bus.hresp),     32'd0);
    check("reset_hrdata",    bus.hrdata,         32'h0);
    check("reset_mem_cs",    32'(mem_cs),        32'd0);
    check("reset_mem_we",    32'(mem_we),        32'd0);

    // One bus cycle per vector: drive after the edge, sample mid-cycle.
    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      hreset = vecs[i].rst;
      drive(vecs[i].sel, vecs[i].tr, vecs[i].wr, vecs[i].sz, vecs[i].addr, vecs[i].wdata);
      @(negedge clk);
      $display("vec %0d: rst=%0b sel=%0b htrans=%0d hwrite=%0b haddr=%h -> rdy=%0b resp=%0b hrdata=%h cs=%0b we=%0b addr=%0d",
               i, vecs[i].rst, vecs[i].sel, vecs[i].tr, vecs[i].wr, vecs[i].addr,
               bus.hreadyout, bus.hresp, bus.hrdata, mem_cs, mem_we, mem_addr);
      check($sformatf("v%0d_hreadyout", i), 32'(bus.hreadyout), 32'(vecs[i].rdy));
      check($sformatf("v%0d_hresp", i),     32'(bus.hresp),     32'(vecs[i].resp));
      check($sformatf("v%0d_hrdata", i),    bus.hrdata,         vecs[i].rdata);
      check($sformatf("v%0d_mem_cs", i),    32'(mem_cs),        32'(vecs[i].cs));
      check($sformatf("v%0d_mem_we", i),    32'(mem_we),        32'(vecs[i].we));
      if (vecs[i].cs) begin
        check($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].maddr));
      end
    end

    // Write then immediately read the same word: count wait states (bounded).
    @(posedge clk);
    #1;
    drive(1'b1, NSQ, 1'b1, W, 32'h20, 32'h0);
    @(posedge clk);
    #1;
    drive(1'b1, NSQ, 1'b0, W, 32'h20, 32'h5A5A0000);
    @(posedge clk);
    #1;
    drive(1'b0, IDL, 1'b0, W, 32'h0, 32'h0);
    waits = 0;
    got   = 1'b0;
    k     = 0;
    while (!got && k < 8) begin
      @(negedge clk);
      if (bus.hreadyout) begin
        got = 1'b1;
      end else begin
        waits++;
        @(posedge clk);
      end
      k++;
    end
    $display("seq wr/rd 0x20: waits=%0d ready=%0b hrdata=%h", waits, got, bus.hrdata);
    check("seq_ready_seen", 32'(got),   32'd1);
    check("seq_wait_count", 32'(waits), 32'd1);
    check("seq_hrdata",     bus.hrdata, 32'h5A5A0000);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/mdmc_ahb_slv.md
Name: mdmc_ahb_slv

Overview:
AHB-lite responder that terminates the bus transfers issued by the mdmc AHB master and maps them onto a single-port synchronous SRAM with 1-cycle read latency. It decodes the address and size, issues memory read/write strobes, and returns read data with zero wait states where possible. It inserts one wait state on the single-port conflict of a read address phase overlapping a write data phase. It returns the two-cycle AHB ERROR response for illegal accesses.

Parameters:
DWIDTH, 32, bus and memory data width in bits (power of two, >= 8)
AWIDTH, 12, memory word-address width; depth = 2^AWIDTH words
OFF (localparam), $clog2(DWIDTH/8), byte-offset bits; native HSIZE value

Ports:
hclk  input  1  clock
hreset  input  1  synchronous reset, active-high
hsel  input  1  slave select from decoder
haddr  input  32  transfer address; [31:24] is the base, ignored here
htrans  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
hwrite  input  1  1 = write
hsize  input  4  transfer size
hwdata  input  DWIDTH  write data, valid in data phase
hready  input  1  bus-level ready (address phase accepted when high)
hreadyout  output  1  slave ready
hresp  output  1  0 OKAY, 1 ERROR
hrdata  output  DWIDTH  read data
mem_cs  output  1  SRAM chip select
mem_we  output  1  SRAM write enable
mem_addr  output  AWIDTH  SRAM word address
mem_wdata  output  DWIDTH  SRAM write data
mem_rdata  input  DWIDTH  SRAM read data, valid the cycle after a read strobe

Behaviour:
- Clock and reset: one clock, hclk. Reset is synchronous and active-high (hreset).
- Accept condition: hsel & hready & htrans[1] at a rising edge. IDLE/BUSY or hsel=0 -> no transfer, OKAY, zero wait.
- Legal access: all of the following must hold:
  - haddr[23:OFF+AWIDTH] == 0
  - haddr[OFF-1:0] == 0
  - hsize == OFF
  Otherwise -> ERROR. No memory strobe is issued for an illegal access.
- Word address: mem_addr = haddr[OFF+AWIDTH-1:OFF], taken from the live haddr in the issuing cycle or from the captured address register.
- States: IDLE, WR, RD, RDW, ERR1, ERR2. Reset -> IDLE.
- Reset values: hreadyout=1, hresp=0, hrdata=0, mem_cs=0, mem_we=0. While hreset=1, mem_cs and mem_we are forced 0.
- Accepted legal write: capture address; next state WR.
  - In WR: mem_cs=1, mem_we=1, mem_addr=captured address, mem_wdata=hwdata (combinational); hreadyout=1.
- Accepted legal read while the port is free (state != WR): mem_cs=1, mem_we=0, mem_addr from live haddr in the address-phase cycle; next state RD.
  - In RD: hreadyout=1, hrdata=mem_rdata.
- Read accepted while in WR (port busy): capture address; next state RDW.
  - In RDW: mem_cs=1, mem_addr=captured address, hreadyout=0, hrdata=0.
  - RDW -> RD: exactly one wait state.
- Accepted illegal access: ERR1 (hreadyout=0, hresp=1) -> ERR2 (hreadyout=1, hresp=1).
- hrdata is 0 in every state except RD.
- Next transfer from WR/RD/ERR2: a new address phase may be accepted in these states (hreadyout=1) and follows the same rules, giving back-to-back pipelining. After a data phase with no new transfer accepted -> IDLE.
- Ignored inputs: inputs are don't-care during RDW/ERR1 since hready=0. An address phase presented then is not accepted; the master holds it.
- Reset mid-operation: a write pending in WR during a reset cycle is discarded (no mem_we). A read in RDW is abandoned. Next state IDLE.
- haddr[31:24] is ignored; base decode is done upstream via hsel.

Optional Feature:
MDMC_AHB_SLV_SUBWORD_EN
- Defined:
  - Adds output port mem_be [DWIDTH/8-1:0].
  - hsize < OFF is legal if haddr is aligned to the size.
  - Writes assert mem_be only for the addressed byte lanes (lane = haddr[OFF-1:0], width 2^hsize bytes).
  - Reads return the full word.
  - hsize > OFF is still an ERROR.
- Undefined: no mem_be port; any hsize != OFF is an ERROR.

Test Plan:
- Write 0xDEADBEEF to haddr 0x0400_0010, IDLE cycle, then read 0x0400_0010 -> write: mem_we=1 at mem_addr 4 in the data phase; read: hrdata=0xDEADBEEF, hreadyout=1 throughout.
- Back-to-back write 0xA5A5A5A5 to 0x8, then read 0x8 -> hreadyout=0 for exactly one cycle (RDW); next cycle hrdata=0xA5A5A5A5.
- Read 0x0000_4000 with AWIDTH=12 (out of range) -> hresp=1 for 2 cycles, hreadyout 0 then 1, mem_cs never asserted.
- Read with hsize=1 (macro undefined), and write to misaligned 0x2 -> each gets the two-cycle ERROR. With the macro defined, a halfword write to 0x2 gives mem_be=4'b1100.
- hreset asserted in the WR cycle of a write to 0xC -> mem_we stays 0; next cycle state IDLE, hreadyout=1; a read of 0xC returns the old value.
- htrans=BUSY and hsel=0 transfers interleaved with reads -> OKAY, zero wait, no mem_cs.
